// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad at a fixed frame rate, shifts in
// the 8 button bits and presents them as registered active-high levels.
// Optional NES_DEBOUNCE_EN: only publish a frame that matches the previous one.
module nes_pad_reader #(
    parameter int unsigned LATCH_CYCLES = 1200,
    parameter int unsigned HALF_CYCLES  = 600,
    parameter int unsigned POLL_CYCLES  = 1666667
) (
    input  logic       clk,
    input  logic       hard_reset_n,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic       btn_start,
    output logic       frame_valid
);

    localparam int unsigned POLL_W = $clog2(POLL_CYCLES);
    localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          buttons_q, buttons_d;
    logic                latch_q, latch_d;
    logic                pulse_q, pulse_d;
    logic                fv_q, fv_d;
    logic                sync1_q, sync2_q;
    logic                tick;
    logic                latch_last;
    logic                half_last;
`ifdef NES_DEBOUNCE_EN
    logic [7:0]          prev_raw_q, prev_raw_d;
`endif

    assign tick       = (poll_cnt_q == POLL_W'(POLL_CYCLES - 1));
    assign latch_last = (phase_q == PH_W'(LATCH_CYCLES - 1));
    assign half_last  = (phase_q == PH_W'(HALF_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous pad data line
    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= nes_data;
            sync2_q <= sync1_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q    <= S_WAIT;
            poll_cnt_q <= '0;
            phase_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buttons_q  <= '0;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b0;
            fv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
            latch_q    <= latch_d;
            pulse_q    <= pulse_d;
            fv_q       <= fv_d;
        end
    end

`ifdef NES_DEBOUNCE_EN
    // Previous raw frame for the two-frame agreement filter
    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            prev_raw_q <= '0;
        end else begin
            prev_raw_q <= prev_raw_d;
        end
    end
`endif

    // Next-state, frame sequencing and output decode
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = tick ? '0 : poll_cnt_q + POLL_W'(1);
        phase_d    = phase_q + PH_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buttons_d  = buttons_q;
`ifdef NES_DEBOUNCE_EN
        prev_raw_d = prev_raw_q;
`endif

        case (state_q)
            S_WAIT: begin
                phase_d = '0;
                if (tick) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (latch_last) begin
                    phase_d = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (half_last) begin
                    // Pad drives low for pressed; store active-high
                    shift_d[bit_idx_q] = ~sync2_q;
                    phase_d            = '0;
                    state_d            = (bit_idx_q == 3'd7) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (half_last) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    phase_d   = '0;
                    state_d   = S_LOW;
                end
            end
            S_DONE: begin
                phase_d   = '0;
                bit_idx_d = '0;
`ifdef NES_DEBOUNCE_EN
                prev_raw_d = shift_q;
                if (shift_q == prev_raw_q) begin
                    buttons_d = shift_q;
                end
`else
                buttons_d = shift_q;
`endif
                state_d = S_WAIT;
            end
            default: begin
                phase_d = '0;
                state_d = S_WAIT;
            end
        endcase

        // Strobes follow the current state one cycle later; frame_valid lines up with DONE
        latch_d = (state_q == S_LATCH);
        pulse_d = (state_q == S_HIGH);
        fv_d    = (state_d == S_DONE);
    end

    assign nes_latch   = latch_q;
    assign nes_pulse   = pulse_q;
    assign buttons     = buttons_q;
    assign btn_start   = buttons_q[3];
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural 4021-style pad model, frame timing
// checks and a scoreboard of expected button words popped on frame_valid.
module tb_nes_pad_reader;

    localparam int unsigned LATCH_CYCLES = 4;
    localparam int unsigned HALF_CYCLES  = 2;
    localparam int unsigned POLL_CYCLES  = 64;

    logic       clk = 1'b0;
    logic       hard_reset_n = 1'b0;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic       btn_start;
    logic       frame_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt   = 0;
    int overlap_cnt = 0;

    logic [7:0] pad_pressed = 8'h00;
    bit         unplugged   = 1'b0;
    logic [7:0] pad_sr      = 8'hFF;
    logic [7:0] exp_q[$];
    logic [7:0] m_prev = 8'h00;
    logic [7:0] m_held = 8'h00;

    nes_pad_reader #(
        .LATCH_CYCLES(LATCH_CYCLES),
        .HALF_CYCLES (HALF_CYCLES),
        .POLL_CYCLES (POLL_CYCLES)
    ) dut (
        .clk         (clk),
        .hard_reset_n(hard_reset_n),
        .nes_data    (nes_data),
        .nes_latch   (nes_latch),
        .nes_pulse   (nes_pulse),
        .buttons     (buttons),
        .btn_start   (btn_start),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Pad model: parallel load on latch, shift toward bit 0 on each pulse rise
    always @(posedge nes_latch or posedge nes_pulse) begin
        if (nes_latch) pad_sr = ~pad_pressed;
        else           pad_sr = {1'b1, pad_sr[7:1]};
    end
    assign nes_data = unplugged ? 1'b1 : pad_sr[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // Reference for the published button word given one raw frame
    function automatic logic [7:0] model(input logic [7:0] raw);
        logic [7:0] e;
`ifdef NES_DEBOUNCE_EN
        e = (raw == m_prev) ? raw : m_held;
`else
        e = raw;
`endif
        m_prev = raw;
        m_held = e;
        return e;
    endfunction

    task automatic queue_frame(input logic [7:0] pressed, input bit unplug);
        pad_pressed = pressed;
        unplugged   = unplug;
        exp_q.push_back(model(unplug ? 8'h00 : pressed));
    endtask

    task automatic wait_frame();
        int  n;
        bit  ok;
        n  = fv_cnt;
        ok = 1'b0;
        for (int i = 0; i < 3 * POLL_CYCLES && !ok; i++) begin
            @(negedge clk);
            if (fv_cnt != n) ok = 1'b1;
        end
        check("frame_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] pressed, input bit unplug);
        queue_frame(pressed, unplug);
        wait_frame();
    endtask

    // Latch and pulse must never overlap
    always @(negedge clk) begin
        assert (!(nes_latch && nes_pulse)) else overlap_cnt++;
    end

    // Scoreboard: compare the published word on the cycle after frame_valid
    always @(negedge clk) begin
        if (hard_reset_n && frame_valid) begin
            logic [7:0] e;
            fv_cnt++;
            @(negedge clk);
            check("fv_width", 32'(frame_valid), 32'd0);
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("buttons", 32'(buttons), 32'(e));
                check("btn_start", 32'(btn_start), 32'(e[3]));
            end
        end
    end

    initial begin
        int first_latch, latch_hi, pulse_rise, pulse_hi, fv1, fv2, fvn;
        bit pp;
        int rises;
        bit got4;
        int n0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_latch",   32'(nes_latch),   32'd0);
        check("rst_pulse",   32'(nes_pulse),   32'd0);
        check("rst_buttons", 32'(buttons),     32'd0);
        check("rst_start",   32'(btn_start),   32'd0);
        check("rst_fv",      32'(frame_valid), 32'd0);

        // Idle pad: two frames, measure frame shape and latency
        queue_frame(8'h00, 1'b0);
        queue_frame(8'h00, 1'b0);
        @(negedge clk);
        hard_reset_n = 1'b1;
        first_latch = 0; latch_hi = 0; pulse_rise = 0; pulse_hi = 0;
        fv1 = 0; fv2 = 0; fvn = 0; pp = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            @(posedge clk);
            #1;
            if (nes_latch && first_latch == 0) first_latch = c;
            if (c <= 100) begin
                if (nes_latch) latch_hi++;
                if (nes_pulse) pulse_hi++;
                if (nes_pulse && !pp) pulse_rise++;
            end
            pp = nes_pulse;
            if (frame_valid) begin
                fvn++;
                if (fv1 == 0) fv1 = c;
                else if (fv2 == 0) fv2 = c;
            end
        end
        check("first_latch_cycle", 32'(first_latch), 32'd65);
        check("latch_high_cycles", 32'(latch_hi),    32'd4);
        check("pulse_count",       32'(pulse_rise),  32'd7);
        check("pulse_high_cycles", 32'(pulse_hi),    32'd14);
        check("fv1_cycle",         32'(fv1),         32'd98);
        check("fv2_cycle",         32'(fv2),         32'd162);
        check("fv_count",          32'(fvn),         32'd2);

        // Pattern decode and filter behaviour
        do_frame(8'h09, 1'b0);
        do_frame(8'h09, 1'b0);
        do_frame(8'h10, 1'b0);
        do_frame(8'h00, 1'b0);
        do_frame(8'h10, 1'b0);
        do_frame(8'h10, 1'b0);
        do_frame(8'hA5, 1'b0);
        do_frame(8'h5A, 1'b0);
        do_frame(8'h5A, 1'b0);

        // Unplugged pad reads as nothing pressed
        do_frame(8'hFF, 1'b1);
        do_frame(8'hFF, 1'b1);

        // Nonzero word, then reset in the middle of bit 4
        do_frame(8'hC3, 1'b0);
        do_frame(8'hC3, 1'b0);
        pad_pressed = 8'h00;
        rises = 0; pp = 1'b0; got4 = 1'b0;
        for (int i = 0; i < 3 * POLL_CYCLES && !got4; i++) begin
            @(negedge clk);
            if (nes_pulse && !pp) rises++;
            pp = nes_pulse;
            if (rises == 4) got4 = 1'b1;
        end
        check("bit4_reached", 32'(got4), 32'd1);
        #2;
        hard_reset_n = 1'b0;
        #1;
        check("mid_rst_latch",   32'(nes_latch),   32'd0);
        check("mid_rst_pulse",   32'(nes_pulse),   32'd0);
        check("mid_rst_buttons", 32'(buttons),     32'd0);
        check("mid_rst_start",   32'(btn_start),   32'd0);
        check("mid_rst_fv",      32'(frame_valid), 32'd0);
        m_prev = 8'h00;
        m_held = 8'h00;
        n0 = fv_cnt;

        // Fresh frames after release; first latch a full poll period later
        queue_frame(8'h81, 1'b0);
        @(negedge clk);
        hard_reset_n = 1'b1;
        first_latch = 0;
        for (int c = 1; c <= 200 && first_latch == 0; c++) begin
            @(posedge clk);
            #1;
            if (nes_latch) first_latch = c;
        end
        check("rst_latch_cycle",  32'(first_latch), 32'd65);
        check("no_partial_fv",    32'(fv_cnt),      32'(n0));
        check("no_partial_btn",   32'(buttons),     32'd0);
        wait_frame();
        do_frame(8'h81, 1'b0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
